// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer.
// Holds the state encoding, the supported opcodes and the datapath select codes.
package mc_ctrl_pkg;

    localparam int OP_W = 6;
    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEX   = 4'd7,
        S_RTWB   = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_next_state.sv
// Combinational next-state function of the multi-cycle control sequencer.
// Flags an unsupported opcode while in DECODE.
module mc_ctrl_next_state
    import mc_ctrl_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] op,
    input  logic            memReady,
    input  logic            start,
    output state_t          nextState,
    output logic            illegal
);

    // Transition table; memory states hold until the handshake completes.
    always_comb begin
        nextState = state;
        illegal   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) nextState = S_FETCH;
                else       nextState = S_IDLE;
            end
            S_FETCH: begin
                if (memReady) nextState = S_DECODE;
                else          nextState = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE: nextState = S_RTEX;
                    OP_ADDI:  nextState = S_ADDIEX;
                    OP_LW:    nextState = S_MEMADR;
                    OP_SW:    nextState = S_MEMADR;
                    OP_BEQ:   nextState = S_BRANCH;
                    OP_J:     nextState = S_JUMP;
                    default: begin
                        nextState = S_FETCH;
                        illegal   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      nextState = S_MEMRD;
                else if (op == OP_SW) nextState = S_MEMWR;
                else                  nextState = S_FETCH;
            end
            S_MEMRD: begin
                if (memReady) nextState = S_MEMWB;
                else          nextState = S_MEMRD;
            end
            S_MEMWR: begin
                if (memReady) nextState = S_FETCH;
                else          nextState = S_MEMWR;
            end
            S_RTEX:   nextState = S_RTWB;
            S_ADDIEX: nextState = S_ADDIWB;
            S_MEMWB, S_RTWB, S_ADDIWB, S_BRANCH, S_JUMP: nextState = S_FETCH;
            default:  nextState = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: state register plus datapath control decode.
// Controls decode from the current state; FETCH's PC/IR loads also wait on mem_ready_i.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [OP_W-1:0] Op_i,
    input  logic            Zero_i,
    input  logic            mem_ready_i,
    output logic            PCWrite_o,
    output logic            PCWriteCond_o,
    output logic            IorD_o,
    output logic            MemRead_o,
    output logic            MemWrite_o,
    output logic            IRWrite_o,
    output logic            MemtoReg_o,
    output logic            RegDst_o,
    output logic            RegWrite_o,
    output logic            ALUSrcA_o,
    output logic [1:0]      ALUSrcB_o,
    output logic [1:0]      ALUOp_o,
    output logic [1:0]      PCSource_o,
    output logic            illegal_o,
    output logic [ST_W-1:0] state_o
);

    state_t stateR;
    state_t nextStateS;
    logic   illegalS;
    logic   unusedZero_s;

    // Zero_i is applied by the datapath through PCWriteCond_o, not by the sequencer.
    assign unusedZero_s = Zero_i;

    mc_ctrl_next_state uNextState (
        .state     (stateR),
        .op        (Op_i),
        .memReady  (mem_ready_i),
        .start     (start_i),
        .nextState (nextStateS),
        .illegal   (illegalS)
    );

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stateR <= S_IDLE;
        else       stateR <= nextStateS;
    end

    assign state_o = stateR;

    // Datapath control decode from the current state.
    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = SRCB_RT;
        ALUOp_o       = ALU_ADD;
        PCSource_o    = PCSRC_ALU;
        illegal_o     = 1'b0;
        case (stateR)
            S_IDLE: begin
                PCWrite_o = 1'b0;
            end
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = SRCB_FOUR;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            S_DECODE: begin
                ALUSrcB_o = SRCB_IMMSH;
                illegal_o = illegalS;
            end
            S_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
            end
            S_MEMWR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
            end
            S_RTEX: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = ALU_FUNCT;
            end
            S_RTWB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = SRCB_IMM;
                ALUOp_o   = ALU_IMM;
            end
            S_ADDIWB: begin
                RegWrite_o = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = ALU_SUB;
                PCWriteCond_o = 1'b1;
                PCSource_o    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = PCSRC_JUMP;
            end
            default: begin
                PCWrite_o = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle MIPS control sequencer that replaces the single-cycle decoder in the next CPU revision.
- Drives the shared datapath (one memory port, one ALU, PC, IR, register file) through fetch/decode/execute/memory/writeback steps per instruction.
- Supports R-type, addi, lw, sw, beq and j.
- Sits between the instruction register's opcode field and all datapath mux selects and write enables. Stalls on a memory ready handshake.

Parameters:
- OP_W, 6, opcode width
- ST_W, 4, state register width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  leave IDLE and begin fetching
- Op_i  in  6  opcode from the instruction register (valid from DECODE onward)
- Zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory access completes this cycle
- PCWrite_o  out  1  unconditional PC load
- PCWriteCond_o  out  1  PC load if Zero_i
- IorD_o  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MemRead_o  out  1  memory read request
- MemWrite_o  out  1  memory write request
- IRWrite_o  out  1  latch instruction register
- MemtoReg_o  out  1  0 = ALUOut, 1 = MDR to write data
- RegDst_o  out  1  0 = rt, 1 = rd
- RegWrite_o  out  1  register file write
- ALUSrcA_o  out  1  0 = PC, 1 = rs
- ALUSrcB_o  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- ALUOp_o  out  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = addi/add-imm
- PCSource_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_o  out  1  one-cycle pulse on an unsupported opcode
- state_o  out  4  current state (debug)

Behaviour:
- Reset (async, any time, including mid-instruction): state = IDLE. All outputs 0, state_o = 0. In-flight memory requests are dropped.
- State encodings:
  - IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6
  - RTEX = 7, RTWB = 8, ADDIEX = 9, ADDIWB = 10, BRANCH = 11, JUMP = 12
  - Codes 13–15 are illegal and go to FETCH next cycle with all outputs 0.
- Outputs are combinational from state. Exceptions: IRWrite_o and PCWrite_o in FETCH are also gated by mem_ready_i.
- IDLE: all outputs 0. If start_i, go to FETCH; otherwise stay.
- FETCH:
  - Always driven: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - If mem_ready_i: IRWrite = 1, PCWrite = 1, next state DECODE. Otherwise hold in FETCH with no PC/IR update.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut). Next state by Op_i:
  - 000000 → RTEX
  - 001000 → ADDIEX
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - any other opcode → FETCH, with illegal_o = 1 this cycle
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state MEMRD if lw, MEMWR if sw.
- MEMRD: MemRead = 1, IorD = 1. If mem_ready_i go to MEMWB; otherwise stay.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Next state FETCH.
- MEMWR: MemWrite = 1, IorD = 1. If mem_ready_i go to FETCH; otherwise stay. MemWrite remains asserted while waiting.
- RTEX: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next state RTWB.
- RTWB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Next state FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 11. Next state ADDIWB.
- ADDIWB: RegWrite = 1, RegDst = 0, MemtoReg = 0. Next state FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Next state FETCH.
- JUMP: PCWrite = 1, PCSource = 10. Next state FETCH.
- Cycle counts (zero wait states), fetch through last state:
  - lw = 5; sw = 4; R-type = 4; addi = 4; beq = 3; j = 3
  - Each memory wait cycle adds 1.
- start_i is ignored outside IDLE. Once running, the FSM never returns to IDLE except through reset.
- Op_i is sampled only in DECODE and MEMADR. It is assumed stable from IRWrite until the next FETCH.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - the state enum/localparams
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J
  - ALUOp codes ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_IMM
  - ALUSrcB and PCSource select constants
- One natural sub-module: mc_ctrl_next_state. It is the combinational next-state function (state, Op_i, mem_ready_i, start_i → next state, illegal). The top module holds the state register and the output decode.

Test Plan:
- Reset, then start_i = 1 with R-type (Op 000000) and mem_ready_i tied high:
  - state sequence 1, 2, 7, 8, 1
  - RTWB cycle: RegWrite = 1, RegDst = 1, ALUOp = 10
  - exactly one PCWrite pulse, in FETCH
- lw (100011) with mem_ready_i low for 2 cycles in FETCH and 3 cycles in MEMRD:
  - FETCH held 3 cycles; IRWrite = PCWrite = 1 only in its last cycle
  - MEMRD held 4 cycles
  - MEMWB: RegWrite = 1, MemtoReg = 1
  - total 10 cycles
- beq (000100) with Zero_i = 1, then again with Zero_i = 0:
  - BRANCH cycle both times: PCWriteCond = 1, PCSource = 01, ALUOp = 01, PCWrite = 0
  - 3 cycles each
- sw (101011) then j (000010):
  - MEMWR: MemWrite = 1, IorD = 1, RegWrite = 0
  - JUMP: PCWrite = 1, PCSource = 10
  - Op 001000 (addi) afterwards: ADDIEX has ALUOp = 11, ALUSrcB = 10
- Illegal opcode 111111 in DECODE:
  - illegal_o = 1 for exactly one cycle; next state FETCH
  - no RegWrite, MemWrite or PCWrite in that cycle
- rst_i asserted mid-MEMWR (asynchronously, between clock edges): MemWrite_o drops to 0 immediately and state_o becomes 0. After release, the FSM stays in IDLE until start_i.
